cnt_if: RTL and testbench
=========================

CNT_IF -- requirements
Module: cnt_if

Interface
REQ-001 Parameter: WIDTH, default 4, counter bit width; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock; all state updates occur on it.
REQ-003 Port: rstn  input  1  reset, asynchronous, active-low.
REQ-004 Port: load  input  WIDTH  value copied into count when load_en=1.
REQ-005 Port: load_en  input  1  synchronous load enable, active-high.
REQ-006 Port: down  input  1  direction select; 1 = decrement, 0 = increment.
REQ-007 Port: rollover  output  1  high while count equals all-ones (2^WIDTH-1).
REQ-008 Port: count  output  WIDTH  current counter value, driven directly from a register.

Function
REQ-009 The block SHALL update count on every rising clk edge while rstn=1; there is no hold or enable state.
REQ-010 Priority per edge SHALL be: load_en=1 -> count<=load; else down=1 -> count<=count-1; else count<=count+1.
REQ-011 load SHALL take priority over down; the value of down SHALL be ignored in a load cycle.
REQ-012 Arithmetic SHALL be modulo 2^WIDTH: decrement from 0 gives 2^WIDTH-1; increment from 2^WIDTH-1 gives 0.
REQ-013 No carry, borrow or saturation SHALL be generated; wrap is silent apart from rollover.
REQ-014 rollover SHALL be combinational: the AND-reduction of count, with no extra register stage.
REQ-015 rollover SHALL be high for exactly the cycles in which count=2^WIDTH-1, whether reached by increment, decrement or load.
REQ-016 Latency: an input sampled at edge N SHALL be reflected on count immediately after edge N, with no added pipeline.
REQ-017 Inputs SHALL be sampled only at clk edges; input changes between edges SHALL have no effect on count.
REQ-018 Loading 2^WIDTH-1 SHALL assert rollover on the next cycle; loading any other value SHALL deassert it.

Reset
REQ-019 When rstn=0, count SHALL go to 0 immediately without waiting for a clk edge, and rollover SHALL go to 0.
REQ-020 While rstn=0, load_en, load and down SHALL be ignored.
REQ-021 After rstn deasserts, the first rising clk edge SHALL apply REQ-010.
REQ-022 Reset asserted mid-count SHALL override any in-progress load or count step.

Structure
REQ-023 The default WIDTH constant SHALL be placed in a shared package, cnt_pkg, for reuse by the bench.
REQ-024 The block SHALL have no sub-module: one register process plus the rollover reduction.

Verification
REQ-025 Reset: hold rstn=0 for 5 clocks -> count=0x0, rollover=0 throughout.
REQ-026 Load: load_en=1, load=0x1, down=1 -> count=0x1 after the next edge; down is ignored.
REQ-027 Down-wrap: count=0x1, load_en=0, down=1 for 3 edges -> count 0x0, then 0xF with rollover=1, then 0xE with rollover=0.
REQ-028 Up-wrap: load 0xE, then load_en=0, down=0 for 2 edges -> 0xF with rollover=1, then 0x0 with rollover=0.
REQ-029 Load all-ones: load_en=1, load=0xF -> count=0xF and rollover=1 after one edge.
REQ-030 Async reset: count=0x7, drop rstn between edges -> count=0x0 immediately; on release with down=0, the first edge gives count=0x1.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared constants for the up/down counter block and its bench.
package cnt_pkg;
  localparam int CNT_WIDTH = 4;
endpackage

// File: rtl/cnt_if_if.sv
// Counter control/status bundle; master drives load/direction, slave reports count.
interface cnt_if_if
  import cnt_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
);
  logic [WIDTH-1:0] load;
  logic             load_en;
  logic             down;
  logic             rollover;
  logic [WIDTH-1:0] count;

  modport master (output load, output load_en, output down, input rollover, input count);
  modport slave  (input load, input load_en, input down, output rollover, output count);
endinterface

// File: rtl/cnt_if.sv
// Free-running modulo-2^WIDTH up/down counter with synchronous load and all-ones flag.
module cnt_if
  import cnt_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] load,
  input  logic             load_en,
  input  logic             down,
  output logic             rollover,
  output logic [WIDTH-1:0] count
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;

  // Load wins over direction; wrap is the natural modulo of the adder.
  always_comb begin
    count_d = count_q + ONE;
    if (load_en)   count_d = load;
    else if (down) count_d = count_q - ONE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count    = count_q;
  assign rollover = &count_q;
endmodule

// File: tb/tb_cnt_if.sv
// Randomized bench for cnt_if against an arithmetic reference model.
module tb_cnt_if;
  import cnt_pkg::*;
  localparam int W = CNT_WIDTH;
  localparam int unsigned MOD = 1 << W;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int unsigned exp_cnt = 0;

  cnt_if_if #(.WIDTH(W)) bus ();

  cnt_if #(.WIDTH(W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .load    (bus.load),
    .load_en (bus.load_en),
    .down    (bus.down),
    .rollover(bus.rollover),
    .count   (bus.count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_cnt"}, 32'(bus.count), exp_cnt);
    chk({tag, "_ro"}, 32'(bus.rollover), 32'(exp_cnt == MOD - 1));
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge,
  // scramble inputs between edges, then check on the following negedge.
  task automatic step(input logic le, input logic [W-1:0] ld, input logic dn, input string tag);
    bus.load_en = le;
    bus.load    = ld;
    bus.down    = dn;
    @(posedge clk);
    if (!rstn)    exp_cnt = 0;
    else if (le)  exp_cnt = ld;
    else if (dn)  exp_cnt = (exp_cnt + MOD - 1) % MOD;
    else          exp_cnt = (exp_cnt + 1) % MOD;
    #1;
    bus.load_en = 1'($urandom);
    bus.load    = W'($urandom);
    bus.down    = 1'($urandom);
    @(negedge clk);
    chk_state(tag);
  endtask

  // Reset pulse dropped between edges; count must clear without a clock.
  task automatic async_reset(input string tag);
    #2 rstn = 1'b0;
    #1;
    exp_cnt = 0;
    chk({tag, "_cnt"}, 32'(bus.count), 32'd0);
    chk({tag, "_ro"}, 32'(bus.rollover), 32'd0);
    @(negedge clk);
    chk_state({tag, "_held"});
    rstn = 1'b1;
  endtask

  initial begin
    bus.load    = '0;
    bus.load_en = 1'b0;
    bus.down    = 1'b0;
    @(negedge clk);
    chk({"rst0_cnt"}, 32'(bus.count), 32'd0);
    for (int i = 0; i < 5; i++)
      step(1'($urandom), W'($urandom), 1'($urandom), "rst_hold");
    rstn = 1'b1;

    step(1'b1, W'(1), 1'b1, "load1_dn_ignored");
    chk("load1_const", 32'(bus.count), 32'h1);
    step(1'b0, '0, 1'b1, "dwrap_a");
    chk("dwrap_a_const", 32'(bus.count), 32'h0);
    step(1'b0, '0, 1'b1, "dwrap_b");
    chk("dwrap_b_const", 32'(bus.count), 32'hF);
    chk("dwrap_b_ro", 32'(bus.rollover), 32'h1);
    step(1'b0, '0, 1'b1, "dwrap_c");
    chk("dwrap_c_const", 32'(bus.count), 32'hE);

    step(1'b1, W'(14), 1'b0, "uwrap_ld");
    step(1'b0, '0, 1'b0, "uwrap_a");
    chk("uwrap_a_ro", 32'(bus.rollover), 32'h1);
    step(1'b0, '0, 1'b0, "uwrap_b");
    chk("uwrap_b_const", 32'(bus.count), 32'h0);

    step(1'b1, '1, 1'b1, "load_ones");
    chk("load_ones_ro", 32'(bus.rollover), 32'h1);
    step(1'b1, W'(5), 1'b0, "load_other");
    chk("load_other_ro", 32'(bus.rollover), 32'h0);

    step(1'b1, W'(7), 1'b0, "pre_ar");
    async_reset("ar");
    step(1'b0, '0, 1'b0, "ar_first");
    chk("ar_first_const", 32'(bus.count), 32'h1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) async_reset("rnd_ar");
      else if ($urandom_range(0, 9) == 0) step(1'b1, '1, 1'($urandom), "rnd_ones");
      else step(($urandom_range(0, 3) == 0), W'($urandom), 1'($urandom), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
